// File: rtl/regfile_stack_pkg.sv
// Shared definitions for the stacked register file and its command sequencer.
// The bank-switch command encoding lives here so both sides agree on it.
package regfile_stack_pkg;

    typedef enum logic [1:0] {
        CMD_NONE = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CMD    = 2'b01,
        ST_SETTLE = 2'b10
    } ctrl_state_t;

endpackage

// File: rtl/regfile_stack_ctrl.sv
// Turns push/pop requests into single-cycle bank-switch commands for the stacked
// register file, tracking depth, guarding overflow/underflow and stalling the core.
module regfile_stack_ctrl
    import regfile_stack_pkg::*;
#(
    parameter int LEVELS = 4,
    parameter int DW     = $clog2(LEVELS)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push_valid,
    output logic          o_push_ready,
    input  logic          i_pop_valid,
    output logic          o_pop_ready,
    input  logic          i_err_clr,
    output logic [1:0]    o_command,
    output logic          o_stall,
    output logic [DW-1:0] o_depth,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_overflow,
    output logic          o_underflow,
    output logic [1:0]    o_dbg_state
);

    localparam logic [DW-1:0] MAX_DEPTH = DW'(LEVELS - 1);

    ctrl_state_t   state_q, state_d;
    cmd_t          command_q, command_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic idle;
    logic full;
    logic empty;
    logic push_acc;
    logic pop_acc;

    // Handshake: a request transfers on an edge where its valid and ready are
    // both high; valid must then be held until that edge. Readies are high only
    // in IDLE, and pop_ready also drops while a push is pending so push wins.
    assign idle         = (state_q == ST_IDLE);
    assign o_push_ready = idle;
    assign o_pop_ready  = idle && !i_push_valid;

    assign full     = (depth_q == MAX_DEPTH);
    assign empty    = (depth_q == '0);
    assign push_acc = i_push_valid && o_push_ready;
    assign pop_acc  = i_pop_valid && o_pop_ready;

    always_comb begin
        state_d     = state_q;
        command_d   = CMD_NONE;
        depth_d     = depth_q;
        overflow_d  = i_err_clr ? 1'b0 : overflow_q;
        underflow_d = i_err_clr ? 1'b0 : underflow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (push_acc) begin
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        state_d   = ST_CMD;
                        command_d = CMD_PUSH;
                        depth_d   = depth_q + 1'b1;
                    end
                end else if (pop_acc) begin
                    if (empty) begin
                        underflow_d = 1'b1;
                    end else begin
                        state_d   = ST_CMD;
                        command_d = CMD_POP;
                        depth_d   = depth_q - 1'b1;
                    end
                end
            end
            ST_CMD:    state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            command_q   <= CMD_NONE;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            command_q   <= command_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_command   = command_q;
    assign o_stall     = !idle;
    assign o_depth     = depth_q;
    assign o_full      = full;
    assign o_empty     = empty;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_regfile_stack_ctrl.sv
// Directed bench for regfile_stack_ctrl with LEVELS = 4: reset, push/pop timing,
// overflow/underflow guards, push priority and reset abort of an in-flight command.
module tb_regfile_stack_ctrl;

    localparam int LEVELS = 4;
    localparam int DW     = $clog2(LEVELS);

    localparam logic [31:0] C_NONE = 32'd0;
    localparam logic [31:0] C_PUSH = 32'd1;
    localparam logic [31:0] C_POP  = 32'd2;

    logic          i_clk;
    logic          i_reset;
    logic          i_push_valid;
    logic          o_push_ready;
    logic          i_pop_valid;
    logic          o_pop_ready;
    logic          i_err_clr;
    logic [1:0]    o_command;
    logic          o_stall;
    logic [DW-1:0] o_depth;
    logic          o_full;
    logic          o_empty;
    logic          o_overflow;
    logic          o_underflow;
    logic [1:0]    o_dbg_state;

    int pass_cnt;
    int total_cnt;

    regfile_stack_ctrl #(.LEVELS(LEVELS)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_push_valid (i_push_valid),
        .o_push_ready (o_push_ready),
        .i_pop_valid  (i_pop_valid),
        .o_pop_ready  (o_pop_ready),
        .i_err_clr    (i_err_clr),
        .o_command    (o_command),
        .o_stall      (o_stall),
        .o_depth      (o_depth),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_overflow   (o_overflow),
        .o_underflow  (o_underflow),
        .o_dbg_state  (o_dbg_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one edge and settle 1ns past it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_push();
        i_push_valid = 1'b1;
        tick();
        i_push_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_pop();
        i_pop_valid = 1'b1;
        tick();
        i_pop_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        i_reset      = 1'b0;
        i_push_valid = 1'b0;
        i_pop_valid  = 1'b0;
        i_err_clr    = 1'b0;

        tick();
        tick();
        check("rst_command", 32'(o_command), C_NONE);
        check("rst_stall", 32'(o_stall), 32'd0);
        check("rst_depth", 32'(o_depth), 32'd0);
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        check("rst_unf", 32'(o_underflow), 32'd0);
        check("rst_push_ready", 32'(o_push_ready), 32'd1);
        check("rst_pop_ready", 32'(o_pop_ready), 32'd1);
        check("rst_state", 32'(o_dbg_state), 32'd0);
        i_reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_command", 32'(o_command), C_NONE);
            check("idle_depth", 32'(o_depth), 32'd0);
            check("idle_empty", 32'(o_empty), 32'd1);
            check("idle_stall", 32'(o_stall), 32'd0);
        end

        // Single push: accepted at edge n.
        i_push_valid = 1'b1;
        tick();
        i_push_valid = 1'b0;
        check("p1_command_n1", 32'(o_command), C_PUSH);
        check("p1_stall_n1", 32'(o_stall), 32'd1);
        check("p1_depth_n1", 32'(o_depth), 32'd1);
        check("p1_push_ready_n1", 32'(o_push_ready), 32'd0);
        check("p1_pop_ready_n1", 32'(o_pop_ready), 32'd0);
        check("p1_state_n1", 32'(o_dbg_state), 32'd1);
        tick();
        check("p1_command_n2", 32'(o_command), C_NONE);
        check("p1_stall_n2", 32'(o_stall), 32'd1);
        check("p1_push_ready_n2", 32'(o_push_ready), 32'd0);
        check("p1_state_n2", 32'(o_dbg_state), 32'd2);
        tick();
        check("p1_stall_n3", 32'(o_stall), 32'd0);
        check("p1_push_ready_n3", 32'(o_push_ready), 32'd1);
        check("p1_empty", 32'(o_empty), 32'd0);

        // Fill to LEVELS-1.
        do_push();
        check("p2_depth", 32'(o_depth), 32'd2);
        check("p2_full", 32'(o_full), 32'd0);
        do_push();
        check("p3_depth", 32'(o_depth), 32'd3);
        check("p3_full", 32'(o_full), 32'd1);

        // Push while full: consumed, no command, overflow set.
        i_push_valid = 1'b1;
        #1;
        check("ovf_ready", 32'(o_push_ready), 32'd1);
        tick();
        i_push_valid = 1'b0;
        check("ovf_command", 32'(o_command), C_NONE);
        check("ovf_stall", 32'(o_stall), 32'd0);
        check("ovf_flag", 32'(o_overflow), 32'd1);
        check("ovf_depth", 32'(o_depth), 32'd3);
        tick();
        check("ovf_sticky", 32'(o_overflow), 32'd1);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        check("ovf_cleared", 32'(o_overflow), 32'd0);

        // Pop down to depth 1.
        i_pop_valid = 1'b1;
        tick();
        i_pop_valid = 1'b0;
        check("pop1_command", 32'(o_command), C_POP);
        check("pop1_depth", 32'(o_depth), 32'd2);
        check("pop1_full", 32'(o_full), 32'd0);
        tick();
        tick();
        do_pop();
        check("pop2_depth", 32'(o_depth), 32'd1);

        // Push and pop together: push first, pop follows three cycles later.
        i_push_valid = 1'b1;
        i_pop_valid  = 1'b1;
        tick();
        i_push_valid = 1'b0;
        check("both_cmd1", 32'(o_command), C_PUSH);
        check("both_depth1", 32'(o_depth), 32'd2);
        tick();
        check("both_gap_a", 32'(o_command), C_NONE);
        tick();
        check("both_gap_b", 32'(o_command), C_NONE);
        tick();
        i_pop_valid = 1'b0;
        check("both_cmd2", 32'(o_command), C_POP);
        check("both_depth2", 32'(o_depth), 32'd1);
        tick();
        tick();

        // Drain to empty.
        do_pop();
        check("drain_depth", 32'(o_depth), 32'd0);
        check("drain_empty", 32'(o_empty), 32'd1);

        // Pop while empty with err_clr in the same cycle: new error wins.
        i_pop_valid = 1'b1;
        i_err_clr   = 1'b1;
        tick();
        i_pop_valid = 1'b0;
        i_err_clr   = 1'b0;
        check("unf_flag", 32'(o_underflow), 32'd1);
        check("unf_command", 32'(o_command), C_NONE);
        check("unf_stall", 32'(o_stall), 32'd0);
        check("unf_depth", 32'(o_depth), 32'd0);
        check("unf_ovf_clear", 32'(o_overflow), 32'd0);

        // Reset in CMD aborts the push.
        i_push_valid = 1'b1;
        tick();
        i_push_valid = 1'b0;
        check("abort_in_cmd", 32'(o_dbg_state), 32'd1);
        i_reset = 1'b0;
        tick();
        check("abort_state", 32'(o_dbg_state), 32'd0);
        check("abort_command", 32'(o_command), C_NONE);
        check("abort_depth", 32'(o_depth), 32'd0);
        check("abort_stall", 32'(o_stall), 32'd0);
        check("abort_unf", 32'(o_underflow), 32'd0);
        i_reset = 1'b1;
        tick();
        check("post_abort_ready", 32'(o_push_ready), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
